// File: rtl/axil_regfile_pkg.sv
// ============================================================================
// Module      : axil_regfile_pkg
// Description : Shared AXI4-Lite response codes and address helpers for
//               axil_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-offset bits below the register index for a given bus width.
    function automatic int addr_lsb(input int data_width);
        return (data_width == 64) ? 3 : 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axil_hold_slot.sv
// ============================================================================
// Module      : axil_hold_slot
// Description : Single-entry valid/ready holding register; loads on handshake,
//               empties on clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Ready is forced low while reset is asserted so nothing is accepted then.
    assign o_ready = !r_full && !rst;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axil_regfile.sv
// ============================================================================
// Module      : axil_regfile
// Description : AXI4-Lite register file with independent AW/W holding slots
//               and a flattened register output. Define AXIL_REGFILE_SLVERR_EN
//               to answer out-of-range accesses with SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_regfile
    import axil_regfile_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_REGS           = 32
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]                    REG_WR_PULSE
);

    localparam int c_dw       = C_S_AXI_DATA_WIDTH;
    localparam int c_sw       = c_dw / 8;
    localparam int c_addr_lsb = addr_lsb(c_dw);
    localparam int c_idx_w    = C_S_AXI_ADDR_WIDTH - c_addr_lsb;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] c_oor_resp = RESP_SLVERR;
`else
    localparam logic [1:0] c_oor_resp = RESP_OKAY;
`endif

    generate
        if (c_dw != 32 && c_dw != 64) begin : g_bad_width
            $error("axil_regfile: C_S_AXI_DATA_WIDTH must be 32 or 64");
        end
        if (NUM_REGS > (1 << c_idx_w)) begin : g_bad_regs
            $error("axil_regfile: NUM_REGS exceeds the decodable address space");
        end
    endgenerate

    logic                          w_aw_full;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_aw_addr;
    logic                          w_w_full;
    logic [c_dw+c_sw-1:0]          w_w_payload;
    logic [c_dw-1:0]               w_wdata;
    logic [c_sw-1:0]               w_wstrb;
    logic [c_idx_w-1:0]            w_aw_idx;
    logic [c_idx_w-1:0]            w_ar_idx;
    logic                          w_aw_in_range;
    logic                          w_ar_in_range;
    logic                          w_commit;
    logic                          w_ar_ready;
    logic [c_dw-1:0]               w_rd_data;
    logic                          w_unused;

    logic [c_dw-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [c_dw-1:0]     r_rdata;

    axil_hold_slot #(.WIDTH(C_S_AXI_ADDR_WIDTH)) u_aw_slot (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .i_valid (S_AXI_AWVALID),
        .o_ready (S_AXI_AWREADY),
        .i_data  (S_AXI_AWADDR),
        .i_clear (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    axil_hold_slot #(.WIDTH(c_dw + c_sw)) u_w_slot (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .i_valid (S_AXI_WVALID),
        .o_ready (S_AXI_WREADY),
        .i_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .i_clear (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_payload)
    );

    assign w_wdata       = w_w_payload[c_dw-1:0];
    assign w_wstrb       = w_w_payload[c_dw+c_sw-1:c_dw];
    assign w_aw_idx      = w_aw_addr[C_S_AXI_ADDR_WIDTH-1:c_addr_lsb];
    assign w_ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_addr_lsb];
    assign w_aw_in_range = {1'b0, w_aw_idx} < (c_idx_w+1)'(NUM_REGS);
    assign w_ar_in_range = {1'b0, w_ar_idx} < (c_idx_w+1)'(NUM_REGS);
    // A pending response that the master has not taken blocks the next commit.
    assign w_commit      = w_aw_full && w_w_full && (!r_bvalid || S_AXI_BREADY);
    assign w_ar_ready    = !S_AXI_ARESET && (!r_rvalid || S_AXI_RREADY);

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        w_aw_addr[c_addr_lsb-1:0], S_AXI_ARADDR[c_addr_lsb-1:0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit && w_aw_in_range) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (i == int'(w_aw_idx)) begin
                        for (int b = 0; b < c_sw; b++) begin
                            if (w_wstrb[b]) begin
                                r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
                            end
                        end
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_in_range ? RESP_OKAY : c_oor_resp;
        end else if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Out-of-range indices match no register and read back as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == int'(w_ar_idx)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (S_AXI_ARVALID && w_ar_ready) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_in_range ? RESP_OKAY : c_oor_resp;
            r_rdata  <= w_rd_data;
        end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_ar_ready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign REG_WR_PULSE  = r_wr_pulse;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
            assign REG_OUT[g*c_dw +: c_dw] = r_regs[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axil_regfile.sv
// ============================================================================
// Module      : tb_axil_regfile
// Description : Scoreboard bench for axil_regfile with a 16-register array
//               model; responses are checked by a monitor at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axil_regfile;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;
    localparam int SW = DW / 8;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    wr_pulse;

    always #5 clk = ~clk;

    axil_regfile #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REG_OUT       (reg_out),
        .REG_WR_PULSE  (wr_pulse)
    );

    int checks = 0;
    int passed = 0;

    logic [DW-1:0]   model [NR];
    int              exp_pulses [NR];
    int              seen_pulses [NR];
    logic [1:0]      exp_b_q [$];
    logic [DW+1:0]   exp_r_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [SW-1:0] s);
        int idx = int'(a) / SW;
        if (idx < NR) begin
            for (int b = 0; b < SW; b++)
                if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            exp_pulses[idx]++;
            exp_b_q.push_back(2'b00);
        end else begin
            exp_b_q.push_back(ERR_RESP);
        end
        return idx;
    endfunction

    function automatic logic [DW+1:0] model_read(input logic [AW-1:0] a);
        int idx = int'(a) / SW;
        if (idx < NR) return {2'b00, model[idx]};
        return {ERR_RESP, {DW{1'b0}}};
    endfunction

    // Monitor: a handshake seen at the falling edge completes on the next rise.
    always @(negedge clk) begin : monitor
        logic [DW+1:0] e;
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", bresp, exp_b_q.pop_front());
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    e = exp_r_q.pop_front();
                    check("rdata", rdata, e[DW-1:0]);
                    check("rresp", rresp, e[DW+1:DW]);
                end
            end
            if (wr_pulse != '0) check("pulse_onehot", $countones(wr_pulse), 1);
            for (int i = 0; i < NR; i++)
                if (wr_pulse[i]) seen_pulses[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [AW-1:0] a);
        bit ok = 0;
        awaddr  = a;
        awvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = awready;
        end
        if (!ok) check("aw_timeout", 0, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = wready;
        end
        if (!ok) check("w_timeout", 0, 1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        bit ok = 0;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) check("ar_timeout", 0, 1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_b_q.size() == 0 && exp_r_q.size() == 0) return;
            tick();
        end
        check("drain_timeout", 64'(exp_b_q.size() + exp_r_q.size()), 0);
        exp_b_q.delete();
        exp_r_q.delete();
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NR; i++) check(name, reg_out[i*DW +: DW], model[i]);
    endtask

    // mode 0: AW then W after gap; mode 1: W then AW; mode 2: both together.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int mode, input int gap, input bit wait_b);
        int idx = model_write(a, d, s);
        case (mode)
            0: begin send_aw(a); repeat (gap) tick(); send_w(d, s); end
            1: begin send_w(d, s); repeat (gap) tick(); send_aw(a); end
            default: fork send_aw(a); send_w(d, s); join
        endcase
        if (wait_b) begin
            check("b_early", bvalid, 0);
            tick();
            check("b_latency", bvalid, 1);
            check("wr_pulse", wr_pulse, (idx < NR) ? (64'd1 << idx) : 64'd0);
            drain();
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_r_q.push_back(model_read(a));
        send_ar(a);
        check("r_latency", rvalid, 1);
        drain();
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW+1:0] e;
        logic [AW-1:0] a;
        int idx;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            model[i] = '0; exp_pulses[i] = 0; seen_pulses[i] = 0;
        end

        repeat (3) tick();
        @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check_regs("rst_reg_out");
        check("rst_pulse", wr_pulse, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        check("post_rst_arready", arready, 1);
        tick();

        // AW first, W three cycles later
        do_write(7'h08, 32'hDEADBEEF, 4'hF, 0, 3, 1);
        check("req041_reg2", reg_out[2*DW +: DW], 32'hDEADBEEF);
        do_read(7'h08);

        // W first, partial strobe merge
        do_write(7'h20, 32'h11223344, 4'hF, 2, 0, 1);
        do_write(7'h20, 32'h0000ABCD, 4'h3, 1, 2, 1);
        check("req042_merge", reg_out[8*DW +: DW], 32'h1122ABCD);
        do_read(7'h20);

        // Zero strobe still commits and pulses
        do_write(7'h20, 32'hFFFFFFFF, 4'h0, 0, 1, 1);
        check("wstrb0_unchanged", reg_out[8*DW +: DW], 32'h1122ABCD);

        // Read on the commit edge returns the pre-write value
        exp_r_q.push_back(model_read(7'h20));
        idx = model_write(7'h20, 32'hCAFEF00D, 4'hF);
        fork send_aw(7'h20); send_w(32'hCAFEF00D, 4'hF); join
        send_ar(7'h20);
        drain();
        check("same_edge_reg", reg_out[8*DW +: DW], 32'hCAFEF00D);

        // Response back-pressure holds the second write in the slots
        bready = 1'b0;
        do_write(7'h10, 32'hA5A5A5A5, 4'hF, 2, 0, 0);
        tick();
        check("bp_bvalid", bvalid, 1);
        held = model[5];
        do_write(7'h14, 32'h5A5A1234, 4'hF, 2, 0, 0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_awready", awready, 0);
            check("bp_wready", wready, 0);
            check("bp_bvalid_hold", bvalid, 1);
            check("bp_no_commit", reg_out[5*DW +: DW], held);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        drain();
        check_regs("bp_regs");

        // Read back-pressure
        do_write(7'h04, 32'h0BADF00D, 4'hF, 2, 0, 1);
        rready = 1'b0;
        e = model_read(7'h04);
        exp_r_q.push_back(e);
        send_ar(7'h04);
        arvalid = 1'b1;
        araddr  = 7'h08;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("rbp_rvalid", rvalid, 1);
            check("rbp_arready", arready, 0);
            check("rbp_rdata", rdata, e[DW-1:0]);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        drain();

        // Back-to-back reads
        for (int n = 0; n < 6; n++) begin
            a = AW'($urandom_range(0, 127));
            exp_r_q.push_back(model_read(a));
            araddr  = a;
            arvalid = 1'b1;
            @(negedge clk);
            check("b2b_arready", arready, 1);
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        drain();

        // Out-of-range register
        do_write(7'h7C, 32'hFFFFFFFF, 4'hF, 2, 0, 1);
        do_read(7'h7C);
        check_regs("oor_regs");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(AW'($urandom_range(0, 127)), DW'($urandom), SW'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1);
            else
                do_read(AW'($urandom_range(0, 127)));
        end
        check_regs("rand_regs");

        // Reset with AW held in the slot and W still pending
        awaddr  = 7'h08;
        awvalid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("mid_rst_awready", awready, 0);
            check("mid_rst_bvalid", bvalid, 0);
            @(posedge clk); #1;
        end
        rst     = 1'b0;
        awvalid = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_regs("post_rst_regs");
        send_w(32'h12345678, 4'hF);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("post_rst_no_b", bvalid, 0);
        end
        @(posedge clk); #1;
        idx = model_write(7'h08, 32'h12345678, 4'hF);
        send_aw(7'h08);
        drain();
        check_regs("post_rst_write");

        tick();
        for (int i = 0; i < NR; i++) check("pulse_count", 64'(seen_pulses[i]), 64'(exp_pulses[i]));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
